// File: rtl/dwt_level_scheduler_pkg.sv
// Shared types and constants for the multi-level DWT scheduler.
package dwt_pkg;
   localparam int unsigned W_WIDTH    = 20;
   localparam int unsigned SAMPLE_W   = 16;
   localparam int unsigned MAX_LEVELS = 8;

   typedef enum logic [2:0] {
      IDLE, CHECK, PRIME, FEED, PAD, NEXT, FINISH
   } state_t;
endpackage

// File: rtl/dwt_level_scheduler_if.sv
// Sample RAM port and filter-pair port seen from the DWT scheduler.
interface dwt_level_scheduler_if #(
   parameter int unsigned ADDR_W = 10
);
   import dwt_pkg::*;

   logic                       rd_en;
   logic [ADDR_W-1:0]          rd_addr;
   logic signed [SAMPLE_W-1:0] rd_data;
   logic                       wr_en;
   logic [ADDR_W-1:0]          wr_addr;
   logic signed [SAMPLE_W-1:0] wr_data;
   logic                       filt_rst;
   logic                       filt_en;
   logic signed [SAMPLE_W-1:0] filt_data;
   logic signed [SAMPLE_W-1:0] lo_data;
   logic signed [SAMPLE_W-1:0] hi_data;
   logic                       filt_we;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, filt_rst, filt_en, filt_data,
      input  rd_data, lo_data, hi_data, filt_we
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, filt_rst, filt_en, filt_data,
      output rd_data, lo_data, hi_data, filt_we
   );
endinterface

// File: rtl/dwt_level_scheduler.sv
// Drives a lo/hi filter pair over the sample RAM for a multi-level 1D DWT;
// approximations are written back in place, details streamed out per level.
module dwt_level_scheduler
   import dwt_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned MIN_LEN = 2
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       start,
   input  logic [ADDR_W:0]            len,
   input  logic [3:0]                 levels,
   output logic                       busy,
   output logic                       done,
   output logic [3:0]                 levels_done,
   output logic                       err,
   dwt_level_scheduler_if.master      bus,
   output logic                       det_valid,
   output logic signed [SAMPLE_W-1:0] det_data,
   output logic [3:0]                 det_level
);

   localparam logic [ADDR_W:0] MIN_N = (ADDR_W+1)'(MIN_LEN);

   state_t          state;
   logic [ADDR_W:0] n_q, rd_cnt, out_cnt, half;
   logic [3:0]      lvl_q, cur_level, lvl_nxt;
   logic            rd_pend, bad_args, last_level, collect;

   always_comb begin
      half       = n_q >> 1;
      lvl_nxt    = cur_level + 4'd1;
      bad_args   = len[0] || (len < MIN_N) || (levels == '0);
      last_level = (lvl_nxt == lvl_q) || (lvl_nxt == 4'(MAX_LEVELS)) ||
                   half[0] || (half < MIN_N);
      collect    = ((state == FEED) || (state == PAD)) && bus.filt_we;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         n_q           <= '0;
         rd_cnt        <= '0;
         out_cnt       <= '0;
         lvl_q         <= '0;
         cur_level     <= '0;
         rd_pend       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         levels_done   <= '0;
         bus.rd_en     <= 1'b0;
         bus.rd_addr   <= '0;
         bus.wr_en     <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.filt_rst  <= 1'b1;
         bus.filt_en   <= 1'b0;
         bus.filt_data <= '0;
         det_valid     <= 1'b0;
         det_data      <= '0;
         det_level     <= '0;
      end else begin
         done         <= 1'b0;
         bus.filt_rst <= 1'b0;
         bus.rd_en    <= 1'b0;
         bus.filt_en  <= 1'b0;
         bus.wr_en    <= 1'b0;
         det_valid    <= 1'b0;

         // Read data returns one cycle after rd_en; forward it to the filters.
         rd_pend <= bus.rd_en;
         if (rd_pend) begin
            bus.filt_en   <= 1'b1;
            bus.filt_data <= bus.rd_data;
         end

         if (collect) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= out_cnt[ADDR_W-1:0];
            bus.wr_data <= bus.lo_data;
            det_valid   <= 1'b1;
            det_data    <= bus.hi_data;
            det_level   <= cur_level;
            out_cnt     <= out_cnt + 1'b1;
         end

         case (state)
            IDLE: begin
               // The done cycle itself must not accept a new start.
               if (start && !done) begin
                  n_q   <= len;
                  lvl_q <= levels;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= CHECK;
               end
            end
            CHECK: begin
               if (bad_args) begin
                  err         <= 1'b1;
                  done        <= 1'b1;
                  levels_done <= '0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cur_level    <= '0;
                  bus.filt_rst <= 1'b1;
                  state        <= PRIME;
               end
            end
            PRIME: begin
               rd_cnt  <= '0;
               out_cnt <= '0;
               state   <= FEED;
            end
            FEED: begin
               if (rd_cnt != n_q) begin
                  bus.rd_en   <= 1'b1;
                  bus.rd_addr <= rd_cnt[ADDR_W-1:0];
                  rd_cnt      <= rd_cnt + 1'b1;
               end else if (!bus.rd_en && !rd_pend) begin
                  state <= PAD;
               end
            end
            PAD: begin
               if (out_cnt == half) begin
                  state <= NEXT;
               end else begin
                  bus.filt_en   <= 1'b1;
                  bus.filt_data <= '0;
               end
            end
            NEXT: begin
               cur_level <= lvl_nxt;
               n_q       <= half;
               if (last_level) begin
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  levels_done <= lvl_nxt;
                  state       <= FINISH;
               end else begin
                  bus.filt_rst <= 1'b1;
                  state        <= PRIME;
               end
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dwt_level_scheduler.sv
// Scoreboard bench for dwt_level_scheduler with a RAM model, a filter-pair
// stand-in and a direct-convolution reference of the multi-level DWT.
module tb_dwt_level_scheduler;
   import dwt_pkg::*;

   localparam int unsigned ADDR_W = 10;
   localparam int MIN_LEN = 2;
   localparam int W       = int'(W_WIDTH);
   localparam int MAXL    = int'(MAX_LEVELS);

   logic              CLK = 1'b0;
   logic              RST_N;
   logic              start;
   logic [ADDR_W:0]   len;
   logic [3:0]        levels;
   logic              busy, done, err, det_valid;
   logic [3:0]        levels_done, det_level;
   logic signed [15:0] det_data;

   always #5 CLK = ~CLK;

   dwt_level_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

   dwt_level_scheduler #(.ADDR_W(ADDR_W), .MIN_LEN(MIN_LEN)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .levels(levels),
      .busy(busy), .done(done), .levels_done(levels_done), .err(err),
      .bus(bus), .det_valid(det_valid), .det_data(det_data), .det_level(det_level)
   );

   // ---------------- sample RAM model ----------------
   logic signed [15:0] ram [0:(1<<ADDR_W)-1];
   logic               ld_en = 1'b0;
   logic [ADDR_W-1:0]  ld_addr;
   logic signed [15:0] ld_data;

   always @(posedge CLK) begin
      if (ld_en) ram[ld_addr] <= ld_data;
      else if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
   end

   // ---------------- filter pair stand-in ----------------
   function automatic int c_lo(int j);
      return (j % 3) + 1;
   endfunction
   function automatic int c_hi(int j);
      return (j % 2 == 0) ? (j % 5) + 1 : -((j % 4) + 1);
   endfunction

   logic signed [15:0] ftap [0:W-2];
   int fcnt;
   int al_c, ah_c;

   always_comb begin
      al_c = c_lo(0) * int'(bus.filt_data);
      ah_c = c_hi(0) * int'(bus.filt_data);
      for (int j = 1; j < W; j++) begin
         al_c += c_lo(j) * int'(ftap[j-1]);
         ah_c += c_hi(j) * int'(ftap[j-1]);
      end
   end

   always @(posedge CLK) begin
      bus.filt_we <= 1'b0;
      if (bus.filt_rst) begin
         fcnt <= 0;
         for (int i = 0; i < W-1; i++) ftap[i] <= '0;
      end else if (bus.filt_en) begin
         ftap[0] <= bus.filt_data;
         for (int i = 1; i < W-1; i++) ftap[i] <= ftap[i-1];
         if (fcnt >= W-1 && ((fcnt - (W-1)) % 2 == 0)) begin
            bus.filt_we <= 1'b1;
            bus.lo_data <= 16'(al_c >>> 5);
            bus.hi_data <= 16'(ah_c >>> 5);
         end
         fcnt <= fcnt + 1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed { logic [15:0] d; logic [3:0] l; } det_t;
   typedef struct packed { logic [ADDR_W-1:0] a; logic [15:0] d; } wr_t;
   typedef struct packed { logic [3:0] ld; logic e; } dn_t;

   det_t exp_det[$];
   wr_t  exp_wr[$];
   dn_t  exp_done[$];
   int   gmem [0:(1<<ADDR_W)-1];

   int checks = 0, errors = 0;
   int rd_seen, rd_pulses, wr_pulses, fen_pulses, done_pulses, last_ld;
   int det_cnt [0:15];

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   function automatic int s16(int v);
      logic signed [15:0] t;
      t = v[15:0];
      return int'(t);
   endfunction

   function automatic longint u16(int v);
      logic [15:0] t;
      t = v[15:0];
      return longint'(t);
   endfunction

   // Direct convolution over the zero-extended level input, one output per
   // odd-aligned position once the W-tap window is full.
   task automatic gold_run(input int n0, input int lv);
      int n, lev, k, idx, s, al, ah;
      int a [0:511];
      if (n0 % 2 != 0 || n0 < MIN_LEN || lv == 0) begin
         exp_done.push_back(dn_t'{ld: 4'd0, e: 1'b1});
         return;
      end
      n = n0;
      lev = 0;
      do begin
         for (int m = 0; m < n/2; m++) begin
            k = W - 1 + 2*m;
            al = 0;
            ah = 0;
            for (int j = 0; j < W; j++) begin
               idx = k - j;
               s = (idx >= 0 && idx < n) ? gmem[idx] : 0;
               al += c_lo(j) * s;
               ah += c_hi(j) * s;
            end
            a[m] = s16(al >>> 5);
            exp_det.push_back(det_t'{d: 16'(ah >>> 5), l: 4'(lev)});
            exp_wr.push_back(wr_t'{a: ADDR_W'(m), d: 16'(a[m])});
         end
         for (int m = 0; m < n/2; m++) gmem[m] = a[m];
         lev++;
         n = n / 2;
      end while (!(lev == lv || lev == MAXL || n % 2 != 0 || n < MIN_LEN));
      exp_done.push_back(dn_t'{ld: 4'(lev), e: 1'b0});
   endtask

   // Monitor: pops expectations whenever the DUT presents a result.
   initial begin : monitor
      det_t e;
      wr_t  w;
      dn_t  dn;
      forever begin
         @(negedge CLK);
         if (RST_N) begin
            if (bus.filt_rst) rd_seen = 0;
            if (bus.rd_en) begin rd_seen++; rd_pulses++; end
            if (bus.filt_en) fen_pulses++;
            if (bus.wr_en || det_valid) chk("wr_det_same_cycle", longint'(bus.wr_en), longint'(det_valid));
            if (bus.wr_en) begin
               wr_pulses++;
               chk("wr_addr_below_rd_cnt", longint'(int'(bus.wr_addr) < rd_seen), 1);
               if (exp_wr.size() == 0) chk("wr_unexpected", longint'(bus.wr_addr), -1);
               else begin
                  w = exp_wr.pop_front();
                  chk("wr_addr", longint'(bus.wr_addr), longint'(w.a));
                  chk("wr_data", u16(int'(bus.wr_data)), longint'(w.d));
               end
            end
            if (det_valid) begin
               det_cnt[det_level]++;
               if (exp_det.size() == 0) chk("det_unexpected", u16(int'(det_data)), -1);
               else begin
                  e = exp_det.pop_front();
                  chk("det_data", u16(int'(det_data)), longint'(e.d));
                  chk("det_level", longint'(det_level), longint'(e.l));
               end
            end
            if (done) begin
               done_pulses++;
               last_ld = int'(levels_done);
               chk("busy_low_at_done", longint'(busy), 0);
               if (exp_done.size() == 0) chk("done_unexpected", longint'(levels_done), -1);
               else begin
                  dn = exp_done.pop_front();
                  chk("levels_done", longint'(levels_done), longint'(dn.ld));
                  chk("err_at_done", longint'(err), longint'(dn.e));
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic clear_counts();
      rd_pulses = 0; wr_pulses = 0; fen_pulses = 0; done_pulses = 0;
      for (int i = 0; i < 16; i++) det_cnt[i] = 0;
   endtask

   task automatic load(input int n, input int kind);
      int v;
      for (int i = 0; i < n; i++) begin
         case (kind)
            0: v = i*16 - 256;
            1: v = (i == 0) ? 1000 : 0;
            default: v = int'($urandom_range(2000, 0)) - 1000;
         endcase
         @(negedge CLK);
         ld_en = 1'b1; ld_addr = ADDR_W'(i); ld_data = 16'(v);
         gmem[i] = v;
      end
      @(negedge CLK);
      ld_en = 1'b0;
   endtask

   task automatic run(input int n, input int lv, input bit disturb, output bit poked);
      int cyc;
      poked = 1'b0;
      gold_run(n, lv);
      clear_counts();
      @(negedge CLK);
      start = 1'b1; len = (ADDR_W+1)'(n); levels = 4'(lv);
      @(negedge CLK);
      start = 1'b0;
      chk("busy_after_start", longint'(busy), 1);
      cyc = 0;
      while (done_pulses == 0 && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
         if (disturb && !poked && det_cnt[1] > 0) begin
            start = 1'b1; len = 11'd8; levels = 4'd1; poked = 1'b1;
         end else start = 1'b0;
      end
      start = 1'b0;
      if (cyc >= 20000) chk("done_timeout", 0, 1);
      repeat (4) @(negedge CLK);
      chk("done_once", done_pulses, 1);
      chk("det_queue_drained", exp_det.size(), 0);
      chk("wr_queue_drained", exp_wr.size(), 0);
      chk("done_queue_drained", exp_done.size(), 0);
   endtask

   initial begin : stim
      bit p;
      int cyc;
      RST_N = 1'b0; start = 1'b0; len = '0; levels = '0;
      clear_counts();
      rd_seen = 0;
      repeat (3) @(negedge CLK);
      chk("rst_outputs_zero", longint'(|{busy, done, err, levels_done, det_valid, det_data, det_level,
          bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.filt_en, bus.filt_data}), 0);
      chk("rst_filt_rst", longint'(bus.filt_rst), 1);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Ramp, three levels
      load(64, 0);
      run(64, 3, 1'b0, p);
      chk("ramp_det_lvl0", det_cnt[0], 32);
      chk("ramp_det_lvl1", det_cnt[1], 16);
      chk("ramp_det_lvl2", det_cnt[2], 8);
      chk("ramp_wr_total", wr_pulses, 56);
      chk("ramp_levels_done", last_ld, 3);
      for (int i = 0; i < 8; i++) chk("ramp_ram_word", u16(int'(ram[i])), u16(gmem[i]));

      // Random data, levels limited by length
      load(64, 2);
      run(64, 8, 1'b0, p);
      chk("deep_levels_done", last_ld, 6);
      chk("deep_err", longint'(err), 0);

      // Rejected arguments
      run(63, 3, 1'b0, p);
      repeat (5) @(negedge CLK);
      chk("odd_err_sticky", longint'(err), 1);
      chk("odd_no_activity", rd_pulses + wr_pulses + fen_pulses, 0);
      run(0, 2, 1'b0, p);
      chk("zero_len_err", longint'(err), 1);
      chk("zero_len_no_activity", rd_pulses + wr_pulses + fen_pulses, 0);
      run(32, 0, 1'b0, p);
      chk("zero_lvl_err", longint'(err), 1);
      chk("zero_lvl_no_activity", rd_pulses + wr_pulses + fen_pulses, 0);

      // Impulse response, single level
      load(32, 1);
      run(32, 1, 1'b0, p);
      chk("impulse_det_count", det_cnt[0], 16);
      chk("impulse_err_cleared", longint'(err), 0);

      // Start pulsed during level 1 must be ignored
      load(64, 2);
      run(64, 3, 1'b1, p);
      chk("disturb_start_issued", longint'(p), 1);
      chk("disturb_levels_done", last_ld, 3);

      // Asynchronous reset during level-1 padding, then a fresh run
      load(64, 2);
      gold_run(64, 3);
      clear_counts();
      @(negedge CLK);
      start = 1'b1; len = 11'd64; levels = 4'd3;
      @(negedge CLK);
      start = 1'b0;
      cyc = 0;
      while (det_cnt[1] < 8 && cyc < 5000) begin
         @(negedge CLK);
         cyc++;
      end
      chk("abort_reached_pad", longint'(det_cnt[1] >= 8), 1);
      #2 RST_N = 1'b0;
      #1;
      chk("abort_outputs_zero", longint'(|{busy, done, err, levels_done, det_valid, det_data, det_level,
          bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data, bus.filt_en, bus.filt_data}), 0);
      chk("abort_filt_rst", longint'(bus.filt_rst), 1);
      exp_det.delete();
      exp_wr.delete();
      exp_done.delete();
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      load(16, 2);
      run(16, 2, 1'b0, p);
      chk("post_reset_levels_done", last_ld, 2);
      chk("post_reset_det_lvl0", det_cnt[0], 8);
      chk("post_reset_det_lvl1", det_cnt[1], 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
